fifo_rd_unpack: RTL and testbench

- Read-side controller for the team's synchronous push/pop FIFO.
- Issues `pop` against the FIFO's registered, non-fall-through `data_out` port and captures each returned word.
- Unpacks each DATA_WIDTH word into NUM_ELEM elements and presents them on a valid/ready stream to the PE array.
- Sustains one element per cycle while the FIFO is non-empty; a 2-word prefetch buffer hides the FIFO's 1-cycle read latency.

---
 rtl/cnn_fifo_pkg.sv | 22 ++
 rtl/fifo_rd_unpack_mux.sv | 15 +
 rtl/fifo_rd_unpack.sv | 106 ++++++++++
 tb/tb_fifo_rd_unpack.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_fifo_pkg.sv
// Shared definitions for the CNN FIFO read/unpack path: default widths,
// an elaboration-time clog2 and the prefetch buffer occupancy type.
package cnn_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int ELEM_WIDTH_DEF = 8;

  typedef logic [1:0] occ_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_rd_unpack_mux.sv
// Combinational element select: picks element i_idx out of a packed word,
// element 0 in the LSBs.
module unpack_mux #(
  parameter int DATA_WIDTH = 64,
  parameter int ELEM_WIDTH = 8,
  parameter int IDX_WIDTH  = 3
) (
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic [IDX_WIDTH-1:0]  i_idx,
  output logic [ELEM_WIDTH-1:0] o_elem
);

  assign o_elem = i_word[i_idx*ELEM_WIDTH +: ELEM_WIDTH];

endmodule

// File: rtl/fifo_rd_unpack.sv
// FIFO read-side controller: pops a registered-output FIFO into a 2-word
// prefetch buffer and streams the words out element by element.
module fifo_rd_unpack
  import cnn_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ELEM_WIDTH = ELEM_WIDTH_DEF,
  parameter int NUM_ELEM   = DATA_WIDTH / ELEM_WIDTH,
  parameter int IDX_WIDTH  = clog2(NUM_ELEM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  output logic                  fifo_pop,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ELEM_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic                  busy
);

  if (NUM_ELEM < 2) begin : g_bad_num_elem
    $error("fifo_rd_unpack: NUM_ELEM must be at least 2");
  end
  if (NUM_ELEM * ELEM_WIDTH != DATA_WIDTH) begin : g_bad_width
    $error("fifo_rd_unpack: DATA_WIDTH must be NUM_ELEM * ELEM_WIDTH");
  end

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ELEM - 1);

  occ_t                  r_occ;
  logic                  r_inflight;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic [DATA_WIDTH-1:0] r_cur;
  logic [DATA_WIDTH-1:0] r_nxt;

  logic                  w_hs;
  logic                  w_retire;
  logic                  w_cap;
  logic                  w_cap_cur;
  logic [ELEM_WIDTH-1:0] w_elem;

  assign out_valid = (r_occ != 2'd0);
  assign w_hs      = out_valid && out_ready;
  assign w_retire  = w_hs && (r_idx == LAST_IDX);
  assign w_cap     = r_inflight && !flush;
  // A returning word lands in cur when cur is empty or is being vacated now.
  assign w_cap_cur = w_cap && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_retire));

  // Credit check uses only registered state, so out_ready never reaches fifo_pop.
  assign fifo_pop = reset && !fifo_empty && !flush &&
                    ((3'(r_occ) + 3'(r_inflight)) < 3'd2);

  assign out_data = out_valid ? w_elem : '0;
  assign out_last = out_valid && (r_idx == LAST_IDX);
  assign out_idx  = r_idx;
  assign busy     = (r_occ != 2'd0) || r_inflight;

  unpack_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .ELEM_WIDTH (ELEM_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_unpack_mux (
    .i_word (r_cur),
    .i_idx  (r_idx),
    .o_elem (w_elem)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_idx      <= '0;
    end else if (flush) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_idx      <= '0;
    end else begin
      r_inflight <= fifo_pop;
      if (w_hs) begin
        r_idx <= w_retire ? '0 : r_idx + 1'b1;
      end
      case ({w_cap, w_retire})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Buffer storage carries no reset; occupancy alone says what is live.
  always_ff @(posedge clk) begin
    if (w_cap_cur) begin
      r_cur <= fifo_data;
    end else if (w_retire) begin
      r_cur <= r_nxt;
    end
    if (w_cap && !w_cap_cur) begin
      r_nxt <= fifo_data;
    end
  end

endmodule

// File: tb/tb_fifo_rd_unpack.sv
// Self-checking bench for fifo_rd_unpack: FIFO model plus an element-queue
// reference fed with the words the FIFO hands out.
module tb_fifo_rd_unpack;

  localparam int DW = 64;
  localparam int EW = 8;
  localparam int NE = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          fifo_pop;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [EW-1:0] out_data;
  logic          out_last;
  logic [IW-1:0] out_idx;
  logic          busy;

  always #5 clk = ~clk;

  fifo_rd_unpack #(.DATA_WIDTH(DW), .ELEM_WIDTH(EW)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .fifo_pop   (fifo_pop),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_idx    (out_idx),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO with registered data_out; pushes become visible one edge later.
  logic [DW-1:0] fq[$];
  always @(posedge clk) begin
    if (fifo_pop && !fifo_empty) fifo_data <= fq.pop_front();
    #1 fifo_empty = (fq.size() == 0);
  end

  typedef struct {
    logic [EW-1:0] d;
    int            i;
  } el_t;

  el_t           eq[$];
  logic          pend = 1'b0;
  logic [DW-1:0] pend_w = '0;
  int            cyc = 0;
  int            n_hs = 0, n_pop = 0, first_pop = -1, first_hs = -1, last_hs = -1;
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_d = '0;
  logic [IW-1:0] prev_i = '0;

  always @(negedge clk) begin
    int   words;
    logic hs, acc;
    el_t  e;
    cyc++;
    if (!reset) begin
      eq.delete();
      pend = 1'b0;
      prev_stall = 1'b0;
    end else begin
      words = (eq.size() + NE - 1) / NE;
      chk("valid", out_valid, eq.size() != 0);
      chk("busy", busy, (eq.size() != 0) || pend);
      chk("pop", fifo_pop, !fifo_empty && !flush && ((words + int'(pend)) < 2));
      if (prev_stall) begin
        chk("hold_data", out_data, prev_d);
        chk("hold_idx", out_idx, prev_i);
      end
      if (out_valid && eq.size() != 0) begin
        chk("data", out_data, eq[0].d);
        chk("idx", out_idx, eq[0].i);
        chk("last", out_last, eq[0].i == NE - 1);
      end
      hs  = out_valid && out_ready;
      acc = fifo_pop && !fifo_empty;
      if (hs) begin
        n_hs++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (acc) begin
        n_pop++;
        if (first_pop < 0) first_pop = cyc;
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_d = out_data;
      prev_i = out_idx;
      if (flush) begin
        eq.delete();
        pend = 1'b0;
      end else begin
        if (hs && eq.size() != 0) void'(eq.pop_front());
        if (pend) begin
          for (int k = 0; k < NE; k++) begin
            e.d = pend_w[k*EW +: EW];
            e.i = k;
            eq.push_back(e);
          end
        end
        pend = acc;
        if (acc) pend_w = fq[0];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    n_hs = 0; n_pop = 0; first_pop = -1; first_hs = -1; last_hs = -1;
  endtask

  task automatic push_rand(input int n);
    for (int k = 0; k < n; k++) fq.push_back({$urandom, $urandom});
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    tick();
    while ((fq.size() != 0 || busy || fifo_pop) && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, n < 3000, 1'b1);
    repeat (2) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_pop", fifo_pop, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    repeat (2) tick();

    // single word
    clr();
    out_ready = 1'b1;
    fq.push_back(64'h0807_0605_0403_0201);
    wait_idle("t1");
    chk("t1_pops", n_pop, 1);
    chk("t1_elems", n_hs, 8);
    chk("t1_latency", first_hs - first_pop, 2);
    chk("t1_span", last_hs - first_hs, 7);

    // streaming
    clr();
    push_rand(4);
    wait_idle("t2");
    chk("t2_pops", n_pop, 4);
    chk("t2_elems", n_hs, 32);
    chk("t2_span", last_hs - first_hs, 31);

    // random backpressure
    clr();
    push_rand(16);
    n = 0;
    while (n_hs < 128 && n < 4000) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("t3_timeout", n < 4000, 1'b1);
    out_ready = 1'b1;
    wait_idle("t3");
    chk("t3_elems", n_hs, 128);
    chk("t3_pops", n_pop, 16);

    // flush while the first pop is returning
    clr();
    push_rand(3);
    n = 0;
    while (!(fifo_pop && !fifo_empty) && n < 50) begin
      tick();
      n++;
    end
    chk("t4_pop_seen", n < 50, 1'b1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_valid", out_valid, 0);
    chk("t4_busy", busy, 0);
    clr();
    wait_idle("t4");
    chk("t4_pops", n_pop, 2);
    chk("t4_elems", n_hs, 16);

    // async reset in the middle of a word
    clr();
    push_rand(2);
    n = 0;
    while (!(out_valid && out_idx == 3'd5) && n < 50) begin
      tick();
      n++;
    end
    chk("t5_idx5_seen", n < 50, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("t5_valid", out_valid, 0);
    chk("t5_pop", fifo_pop, 0);
    chk("t5_idx", out_idx, 0);
    chk("t5_busy", busy, 0);
    repeat (2) tick();
    #1 reset = 1'b1;
    clr();
    push_rand(1);
    wait_idle("t5");
    chk("t5_pops", n_pop, 1);
    chk("t5_elems", n_hs, 8);

    // FIFO drains after three words
    clr();
    push_rand(3);
    wait_idle("t6");
    chk("t6_elems", n_hs, 24);
    chk("t6_span", last_hs - first_hs, 23);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t6_idle_pop", fifo_pop, 0);
      chk("t6_idle_busy", busy, 0);
      chk("t6_idle_valid", out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
